barrel_shift_sequencer: RTL and testbench
=========================================

Name: barrel_shift_sequencer

Overview:
- Upstream control stage for the multi-bit rotating barrel shifter. Holds the operand and generates the rotate amount and direction that drive the shifter each cycle.
- Advances the rotate amount automatically at a prescaled rate (RUN), or one position per request (single-step).
- Typical use: an animated rotating LED/segment pattern on the board.
- All outputs are registered, so the combinational shifter sees glitch-free `a`/`amt`/`lr`.

Parameters:
- N, 3, log2 of data width. Data width W = 2**N; amt width = N.
- TICK_DIV, 50_000_000, clk cycles per automatic step. Legal range 2..2**32-1. Benches use 4.

Ports:
- clk, input, 1, system clock, rising-edge active.
- reset, input, 1, asynchronous, active-high reset.
- load, input, 1, one-cycle pulse: capture din into the operand register.
- din, input, W, operand value to load.
- start, input, 1, pulse: enter or resume automatic stepping.
- stop, input, 1, pulse: pause automatic stepping.
- step, input, 1, pulse: advance amt by one; honoured only when not in RUN.
- dir_in, input, 1, direction request: 1 = left, 0 = right. Sampled on an accepted start or step.
- a, output, W, registered operand; connects to shifter `a`.
- amt, output, N, registered rotate amount; connects to shifter `amt`.
- lr, output, 1, registered direction; connects to shifter `lr`.
- busy, output, 1, high while state == RUN.
- wrap, output, 1, one-cycle pulse when amt advances from 2**N-1 to 0.

Behaviour:
- One clock domain. Only `reset` is asynchronous; every other input is sampled on the rising edge of clk.
- Reset values: a = 0, amt = 0, lr = 0, busy = 0, wrap = 0. State = IDLE, prescaler count = 0.
- States:
  - IDLE: after reset; amt static.
  - RUN: automatic stepping.
  - PAUSE: stopped with position retained.
- Prescaler count runs 0..TICK_DIV-1.
  - Increments only in RUN.
  - Holds its value in PAUSE.
  - Clears to 0 in IDLE, on load, and on start from IDLE.
- Advance event = prescaler at TICK_DIV-1 in RUN, or an accepted step. On an advance event:
  - amt <= amt + 1, modulo 2**N; natural wrap, no saturation.
  - wrap <= 1 for exactly one cycle if the old amt was 2**N-1, else 0.
  - Register updates appear on the edge after the qualifying cycle (latency 1).
- Transitions:
  - IDLE --start--> RUN. lr <= dir_in, count <= 0.
  - RUN --stop--> PAUSE. Count and amt frozen.
  - PAUSE --start--> RUN. lr <= dir_in; count resumes from its held value.
  - IDLE or PAUSE --step--> same state. lr <= dir_in; amt advances once.
  - step in RUN is ignored. start in RUN is ignored; lr does not change.
- load (any state): a <= din, amt <= 0, count <= 0. State is unchanged except as the priority rules below allow.
- Same-cycle priority: load > stop > start > step.
  - load + start: operand loaded, amt = 0, state = RUN, lr <= dir_in.
  - load + step: load wins; no advance.
  - stop + start: stop wins.
  - A prescaler expiry in the same cycle as stop: the advance is lost, and the count is held at TICK_DIV-1. The next start yields an advance one cycle after resume.
- The first automatic advance occurs TICK_DIV cycles after entering RUN from IDLE. Thereafter advances occur every TICK_DIV cycles.
- busy is registered from the next state and equals (state == RUN).
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronously). Inputs are ignored while reset is high.
- Only registers are added; the shifter itself is unchanged.

Decomposition:
- Shared package `barrel_seq_pkg`:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE} seq_state_t;
  - localparam default TICK_DIV.
- Sub-module `mod_m_tick_counter` (params M, width), the prescaler.
  - Inputs: clk, reset, clr, en.
  - Outputs: tick (high when count == M-1 and en), count.
- Sequencer top module: FSM plus the operand, amt and lr registers.

Test Plan (N=3, TICK_DIV=4):
- Reset, then load din=8'hA5 with no start → a=8'hA5, amt=0, busy=0, amt constant for 20 cycles.
- start with dir_in=1 → busy=1 next cycle, lr=1; amt=1 at cycle 4 after start, amt=2 at cycle 8. Shifter output = 8'hA5 rotated left by amt.
- Run 32 cycles from amt=0 → amt sequence 1..7,0; wrap pulses exactly once, one cycle wide, coinciding with amt=0.
- stop at count=2, wait 10 cycles, then start → amt unchanged while paused. Next advance occurs 2 cycles after resume.
- In PAUSE, step three times with dir_in=0 → amt +3, lr=0. Repeat the step in RUN → no change to amt.
- Same-cycle load+start, then reset asserted mid-RUN → load wins with amt=0 and RUN entered. Async reset clears a, amt, busy without waiting for a clk edge.

Source files
------------

// File: rtl/barrel_seq_pkg.sv
// Shared types and constants for the barrel shifter sequencer and its prescaler.
// Holds the FSM state encoding, the default step rate and the counter width helper.
package barrel_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

    localparam int unsigned TICK_DIV_DEFAULT = 32'd50_000_000;

    // Counter width able to hold 0..m-1; never narrower than one bit.
    function automatic int cnt_width(input int unsigned m);
        if (m > 32'd1) begin
            cnt_width = $clog2(m);
        end else begin
            cnt_width = 1;
        end
    endfunction

endpackage

// File: rtl/mod_m_tick_counter.sv
// Modulo-M prescaler: counts 0..M-1 while enabled, holds otherwise.
// tick flags the terminal count of an enabled cycle; clr has priority over en.
module mod_m_tick_counter
    import barrel_seq_pkg::*;
#(
    parameter int unsigned M     = TICK_DIV_DEFAULT,
    parameter int          WIDTH = cnt_width(M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(M - 32'd1);

    logic [WIDTH-1:0] count_r;
    logic             at_last_s;

    assign at_last_s = (count_r == LAST);

    // Prescaler count register; wraps at M-1, holds when not enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            if (at_last_s) begin
                count_r <= {WIDTH{1'b0}};
            end else begin
                count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick  = en && at_last_s;
    assign count = count_r;

endmodule

// File: rtl/barrel_shift_sequencer.sv
// Control stage feeding a rotating barrel shifter: holds the operand and steps the
// rotate amount automatically (RUN) or on request, with glitch-free registered outputs.
module barrel_shift_sequencer
    import barrel_seq_pkg::*;
#(
    parameter int          N        = 3,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [(2**N)-1:0] din,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              dir_in,
    output logic [(2**N)-1:0] a,
    output logic [N-1:0]      amt,
    output logic              lr,
    output logic              busy,
    output logic              wrap
);

    localparam int W  = 2**N;
    localparam int CW = cnt_width(TICK_DIV);

    seq_state_t      state_r;
    seq_state_t      state_s;
    logic [W-1:0]    a_r;
    logic [N-1:0]    amt_r;
    logic            lr_r;
    logic            busy_r;
    logic            wrap_r;

    logic            start_ok_s;
    logic            step_ok_s;
    logic            cnt_clr_s;
    logic            cnt_en_s;
    logic            tick_s;
    logic            adv_s;
    logic [CW-1:0]   cnt_unused_s;

    // Prescaler freezes on stop so an expiry coinciding with stop is held, not lost forever.
    assign cnt_clr_s = load || (state_r == IDLE);
    assign cnt_en_s  = (state_r == RUN) && !stop;

    mod_m_tick_counter #(
        .M     (TICK_DIV),
        .WIDTH (CW)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .tick  (tick_s),
        .count (cnt_unused_s)
    );

    // A load forces amt to zero, so it suppresses any advance in the same cycle.
    assign adv_s = (tick_s && !load) || step_ok_s;

    // Next-state logic with stop > start > step priority outside RUN.
    always_comb begin
        state_s    = state_r;
        start_ok_s = 1'b0;
        step_ok_s  = 1'b0;
        case (state_r)
            IDLE, PAUSE: begin
                if (stop) begin
                    state_s = state_r;
                end else if (start) begin
                    state_s    = RUN;
                    start_ok_s = 1'b1;
                end else if (step && !load) begin
                    step_ok_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (stop) begin
                    state_s = PAUSE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, operand, rotate amount, direction and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            a_r     <= {W{1'b0}};
            amt_r   <= {N{1'b0}};
            lr_r    <= 1'b0;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            wrap_r  <= adv_s && (amt_r == {N{1'b1}});

            if (load) begin
                a_r <= din;
            end else begin
                a_r <= a_r;
            end

            if (load) begin
                amt_r <= {N{1'b0}};
            end else if (adv_s) begin
                amt_r <= amt_r + {{(N-1){1'b0}}, 1'b1};
            end else begin
                amt_r <= amt_r;
            end

            if (start_ok_s || step_ok_s) begin
                lr_r <= dir_in;
            end else begin
                lr_r <= lr_r;
            end
        end
    end

    assign a    = a_r;
    assign amt  = amt_r;
    assign lr   = lr_r;
    assign busy = busy_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Directed bench for barrel_shift_sequencer (N=3, TICK_DIV=4): table of one-pulse
// rows with hand-computed outputs, plus hand sequences for wrap, pause and async reset.
module tb_barrel_shift_sequencer;

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic       st;
        logic       sp;
        logic       stp;
        logic       dir;
        int         n;
        logic [7:0] ea;
        logic [2:0] eamt;
        logic       elr;
        logic       ebusy;
        logic       ewrap;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step = 1'b0;
    logic       dir_in = 1'b0;
    logic [7:0] a;
    logic [2:0] amt;
    logic       lr;
    logic       busy;
    logic       wrap;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[39];

    barrel_shift_sequencer #(.N(3), .TICK_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .din    (din),
        .start  (start),
        .stop   (stop),
        .step   (step),
        .dir_in (dir_in),
        .a      (a),
        .amt    (amt),
        .lr     (lr),
        .busy   (busy),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [7:0] d, input logic st,
                                input logic sp, input logic stp, input logic dir, input int n,
                                input logic [7:0] ea, input logic [2:0] eamt,
                                input logic elr, input logic ebusy, input logic ewrap);
        vec_t v;
        v.ld = ld; v.din = d; v.st = st; v.sp = sp; v.stp = stp; v.dir = dir; v.n = n;
        v.ea = ea; v.eamt = eamt; v.elr = elr; v.ebusy = ebusy; v.ewrap = ewrap;
        return v;
    endfunction

    // What the downstream shifter would produce from a given operand/amount/direction.
    function automatic logic [7:0] rot(input logic [7:0] x, input logic [2:0] s, input logic l);
        logic [15:0] d;
        logic [15:0] r;
        d = {x, x};
        if (l) begin
            r = d << s;
            return r[15:8];
        end else begin
            r = d >> s;
            return r[7:0];
        end
    endfunction

    task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", nm, tag, got, exp);
        end
    endtask

    task automatic chk_all(input int tag, input logic [7:0] ea, input logic [2:0] eamt,
                           input logic elr, input logic ebusy, input logic ewrap);
        chk("a", tag, {24'd0, a}, {24'd0, ea});
        chk("amt", tag, {29'd0, amt}, {29'd0, eamt});
        chk("lr", tag, {31'd0, lr}, {31'd0, elr});
        chk("busy", tag, {31'd0, busy}, {31'd0, ebusy});
        chk("wrap", tag, {31'd0, wrap}, {31'd0, ewrap});
        chk("shifter_out", tag, {24'd0, rot(a, amt, lr)}, {24'd0, rot(ea, eamt, elr)});
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            load = vecs[i].ld; din = vecs[i].din; start = vecs[i].st;
            stop = vecs[i].sp; step = vecs[i].stp; dir_in = vecs[i].dir;
            @(posedge clk); #1;
            load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
            repeat (vecs[i].n - 1) @(posedge clk);
            #1;
            chk_all(i, vecs[i].ea, vecs[i].eamt, vecs[i].elr, vecs[i].ebusy, vecs[i].ewrap);
        end
    endtask

    initial begin
        int wraps;
        // ld din st sp stp dir n | a amt lr busy wrap
        vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1,  8'hA5, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3,  8'hA5, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd1, 1'b1, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4,  8'hA5, 3'd2, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2,  8'hA5, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1,  8'hA5, 3'd0, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10, 8'hA5, 3'd0, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd1, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1,  8'hA5, 3'd1, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'hA5, 3'd2, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'hA5, 3'd3, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'hA5, 3'd4, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1,  8'hA5, 3'd4, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1,  8'hA5, 3'd4, 1'b0, 1'b1, 1'b0);
        vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd4, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd4, 1'b0, 1'b1, 1'b0);
        vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1,  8'hA5, 3'd5, 1'b0, 1'b1, 1'b0);
        vecs[20] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1,  8'hA5, 3'd5, 1'b0, 1'b0, 1'b0);
        vecs[21] = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1,  8'h3C, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[22] = mk(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1,  8'h5A, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2,  8'h5A, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[24] = mk(1'b1, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1,  8'h96, 3'd0, 1'b0, 1'b1, 1'b0);
        vecs[25] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3,  8'h96, 3'd0, 1'b0, 1'b1, 1'b0);
        vecs[26] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1,  8'h96, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[27] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2,  8'h96, 3'd0, 1'b0, 1'b0, 1'b0);
        vecs[28] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1,  8'h96, 3'd0, 1'b1, 1'b1, 1'b0);
        vecs[29] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1,  8'h96, 3'd1, 1'b1, 1'b1, 1'b0);
        vecs[30] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1,  8'h96, 3'd1, 1'b1, 1'b0, 1'b0);
        vecs[31] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'h96, 3'd2, 1'b0, 1'b0, 1'b0);
        vecs[32] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'h96, 3'd3, 1'b0, 1'b0, 1'b0);
        vecs[33] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'h96, 3'd4, 1'b0, 1'b0, 1'b0);
        vecs[34] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'h96, 3'd5, 1'b0, 1'b0, 1'b0);
        vecs[35] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'h96, 3'd6, 1'b0, 1'b0, 1'b0);
        vecs[36] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'h96, 3'd7, 1'b0, 1'b0, 1'b0);
        vecs[37] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  8'h96, 3'd0, 1'b0, 1'b0, 1'b1);
        vecs[38] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1,  8'h96, 3'd0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_all(-1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Load without start: amt must stay put for 20 cycles.
        run_rows(0, 0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_amt_hold", 100 + c, {29'd0, amt}, 32'd0);
        end
        run_rows(1, 4);

        // Reload in RUN, then 32 cycles: amt 1..7,0 and a single wrap pulse with amt=0.
        load = 1'b1; din = 8'hA5;
        @(posedge clk); #1 load = 1'b0;
        chk("reload_amt", 200, {29'd0, amt}, 32'd0);
        wraps = 0;
        for (int j = 1; j <= 32; j++) begin
            @(posedge clk); #1;
            chk("run_amt", 200 + j, {29'd0, amt}, 32'((j / 4) % 8));
            chk("run_wrap", 200 + j, {31'd0, wrap}, (j == 32) ? 32'd1 : 32'd0);
            if (wrap) wraps++;
        end
        chk("wrap_count", 300, 32'(wraps), 32'd1);

        run_rows(5, 23);

        // Asynchronous reset mid-RUN, asserted away from any clock edge.
        #3 reset = 1'b1; load = 1'b1; din = 8'hFF; start = 1'b1;
        #1 chk_all(400, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk_all(401, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; load = 1'b0; start = 1'b0;

        run_rows(24, 38);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
